// File: rtl/shift_sched_if.sv
// Requester/serial-side bundle for shift_sched: two valid/ready word ports plus serial status.
// The master modport is the requester/observer side and the slave modport is the scheduler.
interface shift_sched_if #(
    parameter int WIDTH = 4
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             ser_out;
    logic             ser_en;
    logic             grant_id;
    logic             busy;
    logic             frame_done;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready, ser_out, ser_en, grant_id, busy, frame_done
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready, ser_out, ser_en, grant_id, busy, frame_done
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin two-requester word serializer, MSB first; optional even-parity bit with SHIFT_SCHED_PARITY_EN.
// Latency: first bit one cycle after the handshake edge; frame period WIDTH+2 cycles (WIDTH+3 with parity).
// Backpressure: readys are only raised in IDLE, for the arbitration winner; no acceptance during a frame.
module shift_sched #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    shift_sched_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_SCHED_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
    logic parity_q;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_grant;   // 0 = A, 1 = B
    logic             grant_q;
    logic             grant_a, grant_b, handshake;

    // Arbitration: a lone requester wins; a tie goes to whoever was not granted last.
    always_comb begin
        grant_a   = bus.a_valid && (!bus.b_valid || last_grant);
        grant_b   = bus.b_valid && (!bus.a_valid || !last_grant);
        handshake = (state == IDLE) && !reset && (grant_a || grant_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.a_ready    = 1'b0;
        bus.b_ready    = 1'b0;
        bus.ser_out    = 1'b0;
        bus.ser_en     = 1'b0;
        bus.busy       = (state != IDLE);
        bus.frame_done = 1'b0;
        bus.grant_id   = grant_q;
        case (state)
            IDLE: begin
                bus.a_ready = !reset && grant_a;
                bus.b_ready = !reset && grant_b;
                if (grant_a || grant_b) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bus.ser_en  = 1'b1;
                bus.ser_out = sreg[WIDTH-1];
                if (cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_SCHED_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SHIFT_SCHED_PARITY_EN
            PARITY: begin
                bus.ser_en  = 1'b1;
                bus.ser_out = parity_q;
                state_nxt   = DONE;
            end
`endif
            DONE: begin
                bus.frame_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: data is captured only on the handshake edge, so later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg       <= '0;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
`ifdef SHIFT_SCHED_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (handshake) begin
            sreg       <= grant_b ? bus.b_data : bus.a_data;
            cnt        <= '0;
            last_grant <= grant_b;
            grant_q    <= grant_b;
`ifdef SHIFT_SCHED_PARITY_EN
            parity_q   <= grant_b ? ^bus.b_data : ^bus.a_data;
`endif
        end else if (state == SHIFT) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: frame-level reference model checked every cycle, plus literal frame checks.
module tb_shift_sched;
    localparam int WIDTH = 4;
`ifdef SHIFT_SCHED_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int PERIOD = NB + 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shift_sched_if #(.WIDTH(WIDTH)) bus ();
    shift_sched #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lit(input logic [31:0] plain, input logic [31:0] with_par);
`ifdef SHIFT_SCHED_PARITY_EN
        return with_par;
`else
        return plain;
`endif
    endfunction

    // Frame-level model: a frame is NB serial bits then one done cycle, then idle.
    int          rem    = 0;
    int          idx    = 0;
    logic        m_last = 1'b1;
    logic        m_gid  = 1'b0;
    logic        m_win  = 1'b0;
    logic [31:0] mword  = '0;

    function automatic logic [31:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef SHIFT_SCHED_PARITY_EN
        return {27'd0, d, ^d};
`else
        return {28'd0, d};
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem = 0; idx = 0; m_last = 1'b1; m_gid = 1'b0;
        end else if (rem > 0) begin
            rem--; idx++;
        end else if (bus.a_valid || bus.b_valid) begin
            m_win  = bus.b_valid && (!bus.a_valid || m_last == 1'b0);
            mword  = frame_of(m_win ? bus.b_data : bus.a_data);
            m_gid  = m_win;
            m_last = m_win;
            rem    = NB + 1;
            idx    = 0;
        end
    end

    logic exp_en, exp_out, exp_ar, exp_br;
    always @(negedge clk) begin
        exp_en  = rem > 1;
        exp_out = exp_en ? mword[NB-1-idx] : 1'b0;
        exp_ar  = rem == 0 && !reset && bus.a_valid && (!bus.b_valid || m_last);
        exp_br  = rem == 0 && !reset && bus.b_valid && (!bus.a_valid || !m_last);
        chk("ser_en", bus.ser_en, exp_en);
        chk("ser_out", bus.ser_out, exp_out);
        chk("busy", bus.busy, rem > 0);
        chk("frame_done", bus.frame_done, rem == 1);
        chk("grant_id", bus.grant_id, m_gid);
        chk("a_ready", bus.a_ready, exp_ar);
        chk("b_ready", bus.b_ready, exp_br);
    end

    // Frame log built from the serial stream, for literal checks.
    int          cyc = 0;
    logic [31:0] cur = '0;
    logic [31:0] words[$];
    logic        gids[$];
    int          dcyc[$];
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (reset) begin
            cur = '0;
        end else begin
            if (bus.ser_en) cur = {cur[30:0], bus.ser_out};
            if (bus.frame_done) begin
                words.push_back(cur);
                gids.push_back(bus.grant_id);
                dcyc.push_back(cyc);
                cur = '0;
            end
        end
    end

    task automatic wait_log(input int n);
        int k = 0;
        while (words.size() < n && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("frame_count", words.size(), n);
    endtask

    task automatic send_a(input logic [WIDTH-1:0] d);
        @(posedge clk); #2;
        bus.a_valid = 1'b1; bus.a_data = d;
        @(posedge clk); #2;
        bus.a_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.a_valid = 1'b1; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_data = '0;
        #1;
        chk("rst_ser_en", bus.ser_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_ser_out", bus.ser_out, 0);
        bus.a_valid = 1'b0;
        @(posedge clk); #2;

        // Single request on the first edge after reset release.
        reset = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 4'b1011;
        @(posedge clk); #2;
        bus.a_valid = 1'b0;
        wait_log(1);
        chk("t1_word", words[0], lit(32'hB, 32'h17));
        chk("t1_gid", gids[0], 0);

        // Tie after reset: A first, then alternating at the minimum period.
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 4'hA;
        bus.b_valid = 1'b1; bus.b_data = 4'h5;
        wait_log(5);
        #2;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_word", words[i], (i % 2 == 1) ? lit(32'hA, 32'h14) : lit(32'h5, 32'h0A));
            chk("t2_gid", gids[i], (i % 2 == 1) ? 0 : 1);
        end
        for (int i = 2; i <= 4; i++) chk("t2_period", dcyc[i] - dcyc[i-1], PERIOD);

        // Parity cases.
        send_a(4'b0111);
        wait_log(6);
        send_a(4'b0110);
        wait_log(7);
        chk("t3_word_a", words[5], lit(32'h7, 32'h0F));
        chk("t3_word_b", words[6], lit(32'h6, 32'h0C));
`ifdef SHIFT_SCHED_PARITY_EN
        chk("t3_par1", words[5][0], 1);
        chk("t3_par0", words[6][0], 0);
`endif

        // Data changes right after the handshake edge.
        @(posedge clk); #2;
        bus.a_valid = 1'b1; bus.a_data = 4'hC;
        @(posedge clk); #2;
        bus.a_valid = 1'b0; bus.a_data = 4'h3;
        wait_log(8);
        chk("t4_word", words[7], lit(32'hC, 32'h18));

        // Reset after two bits of 4'hF.
        @(posedge clk); #2;
        bus.a_valid = 1'b1; bus.a_data = 4'hF;
        @(posedge clk); #2;
        bus.a_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t5_ser_en", bus.ser_en, 0);
        chk("t5_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("t5_no_done", words.size(), 8);
        send_a(4'hF);
        wait_log(9);
        chk("t5_word", words[8], lit(32'hF, 32'h1E));

        // B request raised during DONE.
        send_a(4'h9);
        begin
            int k = 0;
            while (!bus.frame_done && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t6_in_done", bus.frame_done, 1);
        #1;
        bus.b_valid = 1'b1; bus.b_data = 4'h6;
        #1;
        chk("t6_b_ready_done", bus.b_ready, 0);
        @(posedge clk); #2;
        chk("t6_b_ready_idle", bus.b_ready, 1);
        @(posedge clk); #2;
        bus.b_valid = 1'b0;
        wait_log(11);
        chk("t6_word_a", words[9], lit(32'h9, 32'h12));
        chk("t6_word_b", words[10], lit(32'h6, 32'h0C));
        chk("t6_gid", gids[10], 1);
        chk("t6_period", dcyc[10] - dcyc[9], PERIOD);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the shift-word width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports a_valid/b_valid, input, 1 bit each: requester A/B has a word to send.
REQ-005 The block SHALL have ports a_data/b_data, input, WIDTH bits each: the requester's word.
REQ-006 The block SHALL have ports a_ready/b_ready, output, 1 bit each: the word is accepted on this edge when valid is also high.
REQ-007 The block SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-008 The block SHALL have port ser_en, output, 1 bit: ser_out is meaningful this cycle.
REQ-009 The block SHALL have port grant_id, output, 1 bit: the source of the current frame (0=A, 1=B).
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-011 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of a frame.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, PARITY (present only with the macro) and DONE.
REQ-013 In IDLE, x_ready SHALL be combinational: it is high only for the requester that arbitration grants; both readys SHALL be low in every other state.
REQ-014 Arbitration SHALL follow these rules:
- If only one requester has valid high, that requester SHALL be granted.
- If both have valid high, the requester that was not granted last SHALL be granted (round-robin).
- The last-grant register SHALL reset to B, so A wins the first tie.
REQ-015 On a handshake edge, the block SHALL perform all of the following:
- Load the winner's data into the internal WIDTH-bit shift register.
- Set grant_id to the winner.
- Update the last-grant register.
- Clear the bit counter.
- Enter SHIFT.
REQ-016 In SHIFT, the block SHALL perform all of the following:
- Drive ser_out as the shift register MSB and hold ser_en at 1.
- On each edge, shift the register left with 0 inserted at the LSB and increment the counter.
- After WIDTH cycles, go to PARITY if the macro is defined, otherwise go to DONE.
REQ-017 Data SHALL be transmitted MSB first; bit i (i=0..WIDTH-1) SHALL appear in the i-th cycle after the handshake edge.
REQ-018 In DONE, the block SHALL hold ser_en at 0 and frame_done at 1 for exactly one cycle, then return to IDLE.
REQ-019 Frame period SHALL be WIDTH+2 cycles from handshake to the next possible handshake (WIDTH+3 with the macro); no back-to-back acceptance SHALL occur in DONE.
REQ-020 A requester SHALL hold valid and data stable until ready; the block SHALL sample data only on the handshake edge, and later changes SHALL have no effect on the frame.
REQ-021 If valid falls while not granted, the block SHALL record no grant and leave the last-grant register unchanged.
REQ-022 The block SHALL derive ser_out, ser_en, busy, frame_done and grant_id from registered state only (no combinational path from inputs).
REQ-023 The counter width SHALL be ceil(log2(WIDTH+1)), and the counter SHALL never wrap within a frame.

Reset
REQ-024 While reset is high, the block SHALL perform all of the following immediately, regardless of clk:
- Go to IDLE.
- Clear the shift register and counter to 0.
- Set last-grant to B.
- Drive ser_out=0, ser_en=0, busy=0, frame_done=0, grant_id=0, a_ready=0 and b_ready=0.
REQ-025 A reset during SHIFT, PARITY or DONE SHALL abort the frame, with no frame_done pulse and no partial bits resumed afterwards.
REQ-026 After reset deasserts, the first rising clk edge SHALL be able to accept a handshake.

Configuration
REQ-027 The block SHALL compile the parity stage in or out with the macro SHIFT_SCHED_PARITY_EN.
REQ-028 With SHIFT_SCHED_PARITY_EN defined, PARITY SHALL last one cycle and perform all of the following:
- Hold ser_en at 1.
- Drive ser_out as even parity, i.e. the XOR of the WIDTH bits accepted at the handshake.
- Proceed to DONE.
REQ-029 Without SHIFT_SCHED_PARITY_EN, the PARITY state and its parity register SHALL be absent, and SHIFT SHALL go directly to DONE.

Verification (WIDTH=4)
REQ-030 The bench SHALL cover single request: A valid with a_data=4'b1011 -> ser_out 1,0,1,1 with ser_en=1 for 4 cycles, then frame_done for 1 cycle and grant_id=0.
REQ-031 The bench SHALL cover the tie after reset: A and B both valid continuously, A=4'hA and B=4'h5 -> frames alternate A,B,A,B with period 6 cycles (7 with the macro).
REQ-032 The bench SHALL cover the parity build: a_data=4'b0111 with SHIFT_SCHED_PARITY_EN -> 5th ser_en bit = 1; a_data=4'b0110 -> 5th bit = 0.
REQ-033 The bench SHALL cover data changed after the handshake: a_data switches from 4'hC to 4'h3 one cycle after a_ready -> serial stream is still 1,1,0,0.
REQ-034 The bench SHALL cover reset mid-frame: reset asserted after 2 bits of 4'hF -> ser_en=0 and busy=0 immediately, no frame_done pulse, and the next frame transmits in full.
REQ-035 The bench SHALL cover request during DONE: B valid raised in DONE -> b_ready stays low until IDLE, then the handshake occurs on the next edge.
